// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_e;

  // Cycles allowed in WAIT_HI for the UART to raise busy before moving on.
  localparam int WAIT_HI_TIMEOUT = 4;

  // Ceiling log2, never less than 1 so a vector is always at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request searching
// ptr+1, ptr+2, ... modulo N_REQ. Returns a one-hot grant and a valid flag.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        grant,
  output logic                    valid
);

  localparam int CW = clog2(N_REQ) + 1;

  logic [CW-1:0]        start;
  logic [2*N_REQ-1:0]   dbl;
  logic [N_REQ-1:0]     rot;
  logic [CW-1:0]        off;
  logic [CW-1:0]        win;
  logic                 found;

  // Rotate requests so ptr+1 lands at bit 0, take the lowest set bit, map back.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    start = {1'b0, ptr} + CW'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int p = 0; p < N_REQ; p++) begin
      if (rot[p] && !found) begin
        found = 1'b1;
        off   = CW'(p);
      end
    end
    win = start + off;
    if (win >= CW'(N_REQ)) win = win - CW'(N_REQ);
    grant = '0;
    for (int i = 0; i < N_REQ; i++) grant[i] = found && (win == CW'(i));
    valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// N_REQ byte-stream requesters. Optional FETCH starvation watchdog is built
// when UART_TX_ARBITER_WATCHDOG_EN is defined; otherwise err_o is tied 0.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 uart_wr_o,
  output logic [7:0]           uart_dat_o,
  input  logic                 uart_busy_i,
  output logic                 active_o,
  output logic                 err_o
);

  localparam int PTR_W = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, pick_grant;
  logic               pick_valid;
  logic [PTR_W-1:0]   ptr_q, owner_idx;
  logic [7:0]         dat_q, owner_byte;
  logic               last_q, owner_valid, owner_last;
  logic [2:0]         hi_cnt_q;
  logic               start_pkt, take_byte, end_pkt;
  logic               wdog_hit;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Encode the current owner and route its byte lane.
  always_comb begin
    owner_idx   = '0;
    owner_byte  = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        owner_idx   = PTR_W'(k);
        owner_byte  = req_data_i[8*k +: 8];
        owner_valid = req_valid_i[k];
        owner_last  = req_last_i[k];
      end
    end
  end

`ifdef UART_TX_ARBITER_WATCHDOG_EN
  localparam int WDOG_W = clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;

  assign wdog_hit = (state_q == FETCH) && !owner_valid &&
                    (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Count consecutive starved FETCH cycles; any other cycle restarts it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wdog_hit;
      if (state_q == FETCH && !owner_valid) wdog_q <= wdog_q + WDOG_W'(1);
      else                                  wdog_q <= '0;
    end
  end

  assign err_o = err_q;
`else
  assign wdog_hit = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Next-state decode; the three strobes steer the datapath registers.
  always_comb begin
    state_d   = state_q;
    start_pkt = 1'b0;
    take_byte = 1'b0;
    end_pkt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          start_pkt = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (owner_valid) begin
          take_byte = 1'b1;
          state_d   = ISSUE;
        end else if (wdog_hit) begin
          end_pkt = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!uart_busy_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (uart_busy_i || hi_cnt_q == 3'(WAIT_HI_TIMEOUT - 1)) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!uart_busy_i) begin
          if (last_q) begin
            end_pkt = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk_i) begin
    // NOTE: reset is synchronous and only takes effect on the clock edge.
    if (sys_rst_i) state_q <= IDLE;
    // NOTE: registers use <= so every flop samples pre-edge values.
    else           state_q <= state_d;
  end

  // Owner, round-robin pointer and byte/last holding registers.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      grant_q <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      dat_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      if (start_pkt) grant_q <= pick_grant;
      if (take_byte) begin
        dat_q  <= owner_byte;
        last_q <= owner_last;
      end
      if (end_pkt) begin
        grant_q <= '0;
        ptr_q   <= owner_idx;
      end
    end
  end

  // WAIT_HI dwell counter guarding a missed busy rising edge.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)               hi_cnt_q <= '0;
    else if (state_q == WAIT_HI) hi_cnt_q <= hi_cnt_q + 3'd1;
    else                         hi_cnt_q <= '0;
  end

  assign req_ready_o = (state_q == FETCH) ? grant_q : '0;
  assign grant_o     = grant_q;
  assign uart_wr_o   = (state_q == ISSUE);
  assign uart_dat_o  = dat_q;
  assign active_o    = (state_q != IDLE);

endmodule
